hilo_muldiv_unit: RTL and testbench

- Multi-cycle HI/LO unit beside the 32-bit ALU.
- Owns the architectural HI and LO registers.
- Sequences iterative multiply, multiply-accumulate and multiply-subtract, plus MTHI/MTLO.
- Gives the pipeline a Busy/Done handshake so the hazard unit can stall MFHI/MFLO and further HI/LO ops.

---
 rtl/hilo_pkg.sv | 32 +++
 rtl/hilo_iter_core.sv | 54 +++++
 rtl/hilo_muldiv_unit.sv | 183 ++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: op codes, FSM encoding and shared constants for the HI/LO unit.
// Optional divide support is enabled with the HILO_DIV_EN macro.
// Iteration count is derived from the bits retired per RUN cycle.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_DIV   = 3'b110;
  localparam logic [2:0] OP_DIVU  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_SIGN  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // Wide enough to hold N-1 for the slowest legal setting (N = 32).
  localparam int CNT_W = 5;

  // Quotient reported for a zero divisor.
  localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;

  function automatic int iter_count(input int bpc);
    return 32 / bpc;
  endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// hilo_iter_core: one RUN-cycle datapath step, purely combinational.
// Multiply: shift-add BITS_PER_CYCLE multiplier bits into the 64-bit accumulator.
// With HILO_DIV_EN: restoring divide, acc = {remainder, dividend/quotient}.
module hilo_iter_core #(
  parameter int BITS_PER_CYCLE = 1
) (
`ifdef HILO_DIV_EN
  input  logic        i_div,
`endif
  input  logic [63:0] i_acc,
  input  logic [63:0] i_mcand,
  input  logic [31:0] i_mplier,
  output logic [63:0] o_acc,
  output logic [63:0] o_mcand,
  output logic [31:0] o_mplier
);

`ifdef HILO_DIV_EN
  logic [32:0] w_rem;
`endif

  // Retire BITS_PER_CYCLE multiplier bits, or BITS_PER_CYCLE quotient bits when dividing.
  always_comb begin
    o_acc    = i_acc;
    o_mcand  = i_mcand;
    o_mplier = i_mplier;
`ifdef HILO_DIV_EN
    w_rem    = '0;
    if (i_div) begin
      // Divisor lives in i_mcand[31:0] and is left untouched.
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
        w_rem = {o_acc[63:32], o_acc[31]};
        o_acc = {o_acc[62:0], 1'b0};
        if (w_rem >= {1'b0, i_mcand[31:0]}) begin
          w_rem    = w_rem - {1'b0, i_mcand[31:0]};
          o_acc[0] = 1'b1;
        end
        // Partial remainder is always below the divisor, so it fits 32 bits.
        o_acc[63:32] = w_rem[31:0];
      end
    end else
`endif
    begin
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
        if (i_mplier[k]) begin
          o_acc = o_acc + (i_mcand << k);
        end
      end
      o_mcand  = i_mcand << BITS_PER_CYCLE;
      o_mplier = i_mplier >> BITS_PER_CYCLE;
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO registers plus iterative MULT/MULTU/MADD/MSUB and MTHI/MTLO.
// Latency: Done in cycle N+3 after Start (N = 32/BITS_PER_CYCLE); MTHI/MTLO Done next cycle.
// Busy while in flight; Start while Busy is ignored. HILO_DIV_EN adds DIV/DIVU.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam int N = iter_count(BITS_PER_CYCLE);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_neg;
  logic [63:0]      r_acc;
  logic [63:0]      r_mcand;
  logic [31:0]      r_mplier;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_done;
`ifdef HILO_DIV_EN
  logic             r_rneg;
  logic             r_dz;
`endif

  logic        w_is_div;
  logic        w_is_iter;
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [63:0] w_acc_nxt;
  logic [63:0] w_mcand_nxt;
  logic [31:0] w_mplier_nxt;
  logic [63:0] w_acc_fix;
  logic [63:0] w_hilo_wr;

`ifdef HILO_DIV_EN
  assign w_is_div = (Op == OP_DIV) || (Op == OP_DIVU);
`else
  assign w_is_div = 1'b0;
`endif
  assign w_is_iter = ~Op[2] | w_is_div;
  assign w_signed  = (Op != OP_MULTU) && (Op != OP_DIVU);
  assign w_a_neg   = w_signed & A[31];
  assign w_b_neg   = w_signed & B[31];
  assign w_a_mag   = w_a_neg ? -A : A;
  assign w_b_mag   = w_b_neg ? -B : B;

  hilo_iter_core #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_core (
`ifdef HILO_DIV_EN
    .i_div   (r_op[2]),
`endif
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_mplier(r_mplier),
    .o_acc   (w_acc_nxt),
    .o_mcand (w_mcand_nxt),
    .o_mplier(w_mplier_nxt)
  );

  // Sign fix-up: negate the product, or quotient/remainder independently when dividing.
  always_comb begin
    w_acc_fix = r_neg ? -r_acc : r_acc;
`ifdef HILO_DIV_EN
    if (r_op[2]) begin
      w_acc_fix[31:0]  = r_dz ? DIV0_QUOT : (r_neg ? -r_acc[31:0] : r_acc[31:0]);
      w_acc_fix[63:32] = r_rneg ? -r_acc[63:32] : r_acc[63:32];
    end
`endif
  end

  // Value written into {HI,LO}: plain product/quotient, or accumulate/subtract with wrap.
  always_comb begin
    case (r_op)
      OP_MADD: w_hilo_wr = {r_hi, r_lo} + r_acc;
      OP_MSUB: w_hilo_wr = {r_hi, r_lo} - r_acc;
      default: w_hilo_wr = r_acc;
    endcase
  end

  // Control FSM, iteration counter, work registers and HI/LO with Done pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
`ifdef HILO_DIV_EN
      r_rneg   <= 1'b0;
      r_dz     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (Flush) begin
        // Abort wins over everything, including a Start in IDLE and a pending write.
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (Start) begin
              if (Op == OP_MTHI) begin
                r_hi   <= A;
                r_done <= 1'b1;
              end else if (Op == OP_MTLO) begin
                r_lo   <= A;
                r_done <= 1'b1;
              end else if (w_is_iter) begin
                r_op    <= Op;
                r_cnt   <= CNT_W'(N - 1);
                r_state <= S_RUN;
                if (w_is_div) begin
                  r_acc    <= {32'b0, w_a_mag};
                  r_mcand  <= {32'b0, w_b_mag};
                  r_mplier <= '0;
                  // A zero divisor reports an all-ones quotient regardless of signs.
                  r_neg    <= (w_a_neg ^ w_b_neg) && (B != 32'd0);
                end else begin
                  r_acc    <= '0;
                  r_mcand  <= {32'b0, w_a_mag};
                  r_mplier <= w_b_mag;
                  r_neg    <= w_a_neg ^ w_b_neg;
                end
`ifdef HILO_DIV_EN
                r_rneg <= w_a_neg;
                r_dz   <= (B == 32'd0);
`endif
              end
            end
          end
          S_RUN: begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            if (r_cnt == '0) begin
              r_state <= S_SIGN;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_SIGN: begin
            r_acc   <= w_acc_fix;
            r_state <= S_WRITE;
          end
          S_WRITE: begin
            {r_hi, r_lo} <= w_hilo_wr;
            r_done       <= 1'b1;
            r_state      <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign Busy = (r_state != S_IDLE);
  assign Done = r_done;
  assign Hi   = r_hi;
  assign Lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: scoreboarded bench for the HI/LO multiply/divide unit.
// Expected {Hi,Lo} values are pushed when an op is started and popped on Done.
// Divide scenarios are selected by HILO_DIV_EN.
module tb_hilo_muldiv_unit;

  localparam int BPC = 1;
  localparam int N   = 32 / BPC;

  localparam logic [2:0] T_MULT  = 3'b000;
  localparam logic [2:0] T_MULTU = 3'b001;
  localparam logic [2:0] T_MADD  = 3'b010;
  localparam logic [2:0] T_MSUB  = 3'b011;
  localparam logic [2:0] T_MTHI  = 3'b100;
  localparam logic [2:0] T_MTLO  = 3'b101;
  localparam logic [2:0] T_DIV   = 3'b110;
  localparam logic [2:0] T_DIVU  = 3'b111;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] m_hilo = 64'd0;

  hilo_muldiv_unit #(.BITS_PER_CYCLE(BPC)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Start(Start),
    .Op   (Op),
    .A    (A),
    .B    (B),
    .Flush(Flush),
    .Busy (Busy),
    .Done (Done),
    .Hi   (Hi),
    .Lo   (Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference behaviour of {HI,LO} after an op, from plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hilo);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    sa = a;
    sb = b;
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up = {32'b0, a} * {32'b0, b};
    case (op)
      T_MULT:  return sp;
      T_MULTU: return up;
      T_MADD:  return hilo + sp;
      T_MSUB:  return hilo - sp;
      T_MTHI:  return {a, hilo[31:0]};
      T_MTLO:  return {hilo[63:32], a};
      T_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Scoreboard: every Done must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Reset && Done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: Done=1 with no op outstanding, Hi=%h Lo=%h", Hi, Lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({Hi, Lo} !== e) begin
          errors++;
          $display("FAIL scoreboard_hilo: got %h expected %h", {Hi, Lo}, e);
        end
      end
    end
  end

  // Drive one Start cycle at the current negedge; returns at the negedge of cycle 1.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit push);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    if (push) begin
      m_hilo = model(op, a, b, m_hilo);
      exp_q.push_back(m_hilo);
    end
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Wait (bounded) for Done; dcyc is the cycle number relative to Start, -1 on timeout.
  task automatic run_to_done(output int dcyc);
    dcyc = -1;
    for (int c = 1; c <= N + 20; c++) begin
      if (Done === 1'b1) begin
        dcyc = c;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b0;
    Flush = 1'b0;
    Op    = 3'b000;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge Clk);
    checks++; if (Hi !== 32'h0)   begin errors++; $display("FAIL reset_hi: got %h expected 0", Hi); end
    checks++; if (Lo !== 32'h0)   begin errors++; $display("FAIL reset_lo: got %h expected 0", Lo); end
    checks++; if (Busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (Done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_run();
    int d;
    start_op(T_MTHI, 32'h12345678, 32'h0, 1'b1);
    run_to_done(d);
    checks++; if (d !== 1) begin errors++; $display("FAIL mthi_latency: got %0d expected 1", d); end
    @(negedge Clk);
    start_op(T_MULT, 32'd3, 32'd4, 1'b0);
    repeat (8) @(negedge Clk);
    Reset = 1'b1;
    #1;
    checks++; if (Hi !== 32'h0)  begin errors++; $display("FAIL midrun_reset_hi: got %h expected 0", Hi); end
    checks++; if (Lo !== 32'h0)  begin errors++; $display("FAIL midrun_reset_lo: got %h expected 0", Lo); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy: got %b expected 0", Busy); end
    exp_q.delete();
    m_hilo = 64'd0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_mult_timing();
    logic eb;
    logic ed;
    start_op(T_MULT, 32'hFFFFFFFD, 32'd7, 1'b1);
    for (int k = 1; k <= N + 4; k++) begin
      eb = (k <= N + 2);
      ed = (k == N + 3);
      checks++;
      if (Busy !== eb) begin errors++; $display("FAIL mult_busy_c%0d: got %b expected %b", k, Busy, eb); end
      checks++;
      if (Done !== ed) begin errors++; $display("FAIL mult_done_c%0d: got %b expected %b", k, Done, ed); end
      @(negedge Clk);
    end
    checks++; if (Hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", Hi); end
    checks++; if (Lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo: got %h expected ffffffeb", Lo); end
  endtask

  task automatic test_back_to_back();
    int d;
    start_op(T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    run_to_done(d);
    checks++; if (d !== N + 3) begin errors++; $display("FAIL multu_latency: got %0d expected %0d", d, N + 3); end
    checks++; if (Hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", Hi); end
    checks++; if (Lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", Lo); end
    // Start in the Done cycle must be accepted.
    start_op(T_MULT, 32'h00000010, 32'hFFFFFFFE, 1'b1);
    run_to_done(d);
    checks++; if (d !== N + 3) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", d, N + 3); end
    checks++; if ({Hi, Lo} !== 64'hFFFFFFFF_FFFFFFE0) begin errors++; $display("FAIL b2b_hilo: got %h expected ffffffffffffffe0", {Hi, Lo}); end
    @(negedge Clk);
  endtask

  task automatic test_mthi_madd();
    int d;
    start_op(T_MTHI, 32'd5, 32'd0, 1'b1);
    run_to_done(d);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", Busy); end
    @(negedge Clk);
    start_op(T_MTLO, 32'hFFFFFFFF, 32'd0, 1'b1);
    run_to_done(d);
    checks++; if ({Hi, Lo} !== 64'h00000005_FFFFFFFF) begin errors++; $display("FAIL mtlo_hilo: got %h expected 00000005ffffffff", {Hi, Lo}); end
    @(negedge Clk);
    start_op(T_MADD, 32'd2, 32'd3, 1'b1);
    run_to_done(d);
    checks++; if (d !== N + 3) begin errors++; $display("FAIL madd_latency: got %0d expected %0d", d, N + 3); end
    checks++; if ({Hi, Lo} !== 64'h00000006_00000005) begin errors++; $display("FAIL madd_hilo: got %h expected 0000000600000005", {Hi, Lo}); end
    @(negedge Clk);
  endtask

  task automatic test_msub_busy_start();
    int d;
    start_op(T_MTHI, 32'd0, 32'd0, 1'b1);
    run_to_done(d);
    @(negedge Clk);
    start_op(T_MTLO, 32'd0, 32'd0, 1'b1);
    run_to_done(d);
    @(negedge Clk);
    start_op(T_MSUB, 32'd1, 32'd1, 1'b1);
    repeat (9) @(negedge Clk);
    // Cycle 10: a Start while Busy must be ignored.
    start_op(T_MTHI, 32'hDEADBEEF, 32'd0, 1'b0);
    run_to_done(d);
    checks++; if (d + 10 !== N + 3) begin errors++; $display("FAIL msub_latency: got %0d expected %0d", d + 10, N + 3); end
    checks++; if ({Hi, Lo} !== 64'hFFFFFFFF_FFFFFFFF) begin errors++; $display("FAIL msub_hilo: got %h expected ffffffffffffffff", {Hi, Lo}); end
    @(negedge Clk);
  endtask

  task automatic test_flush();
    int seen;
    start_op(T_MULT, 32'd123, 32'd456, 1'b0);
    repeat (19) @(negedge Clk);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL flush_busy_c21: got %b expected 0", Busy); end
    seen = 0;
    repeat (N + 5) begin
      if (Done === 1'b1) seen++;
      @(negedge Clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses expected 0", seen); end
    checks++; if ({Hi, Lo} !== m_hilo) begin errors++; $display("FAIL flush_hilo: got %h expected %h", {Hi, Lo}, m_hilo); end
    // Flush together with Start in IDLE: nothing accepted.
    Flush = 1'b1; Start = 1'b1; Op = T_MULT; A = 32'd9; B = 32'd9;
    @(negedge Clk);
    Flush = 1'b0; Start = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b expected 0", Busy); end
    Flush = 1'b1; Start = 1'b1; Op = T_MTHI; A = 32'hCAFEF00D;
    @(negedge Clk);
    Flush = 1'b0; Start = 1'b0;
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL flush_mthi_done: got %b expected 0", Done); end
    checks++; if (Hi !== m_hilo[63:32]) begin errors++; $display("FAIL flush_mthi_hi: got %h expected %h", Hi, m_hilo[63:32]); end
    // Flush during WRITE suppresses the register update.
    start_op(T_MULTU, 32'd2, 32'd3, 1'b0);
    repeat (N + 1) @(negedge Clk);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b expected 1", Busy); end
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL flush_write_done: got %b expected 0", Done); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL flush_write_busy: got %b expected 0", Busy); end
    checks++; if ({Hi, Lo} !== m_hilo) begin errors++; $display("FAIL flush_write_hilo: got %h expected %h", {Hi, Lo}, m_hilo); end
    @(negedge Clk);
  endtask

`ifdef HILO_DIV_EN
  task automatic test_div();
    int d;
    start_op(T_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
    run_to_done(d);
    checks++; if (d !== N + 3) begin errors++; $display("FAIL div_latency: got %0d expected %0d", d, N + 3); end
    checks++; if ({Hi, Lo} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_neg7_2: got %h expected fffffffffffffffd", {Hi, Lo}); end
    start_op(T_DIVU, 32'd9, 32'd0, 1'b1);
    run_to_done(d);
    checks++; if (d !== N + 3) begin errors++; $display("FAIL divu0_latency: got %0d expected %0d", d, N + 3); end
    checks++; if ({Hi, Lo} !== 64'h00000009_FFFFFFFF) begin errors++; $display("FAIL divu_9_0: got %h expected 00000009ffffffff", {Hi, Lo}); end
    start_op(T_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    run_to_done(d);
    checks++; if ({Hi, Lo} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_ovf: got %h expected 0000000080000000", {Hi, Lo}); end
    start_op(T_DIV, 32'hFFFFFFFB, 32'd0, 1'b1);
    run_to_done(d);
    checks++; if ({Hi, Lo} !== 64'hFFFFFFFB_FFFFFFFF) begin errors++; $display("FAIL div_neg5_0: got %h expected fffffffbffffffff", {Hi, Lo}); end
    start_op(T_DIVU, 32'hFFFFFFF0, 32'd7, 1'b1);
    run_to_done(d);
    @(negedge Clk);
  endtask
`else
  task automatic test_illegal_div();
    int busy_seen;
    int done_seen;
    start_op(T_DIV, 32'd7, 32'd2, 1'b0);
    busy_seen = 0;
    done_seen = 0;
    repeat (N + 5) begin
      if (Busy === 1'b1) busy_seen++;
      if (Done === 1'b1) done_seen++;
      @(negedge Clk);
    end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL div_illegal_busy: got %0d cycles expected 0", busy_seen); end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL div_illegal_done: got %0d pulses expected 0", done_seen); end
    start_op(T_DIVU, 32'd9, 32'd0, 1'b0);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL divu_illegal_busy: got %b expected 0", Busy); end
    @(negedge Clk);
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL divu_illegal_done: got %b expected 0", Done); end
    checks++; if ({Hi, Lo} !== m_hilo) begin errors++; $display("FAIL div_illegal_hilo: got %h expected %h", {Hi, Lo}, m_hilo); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_run();
    test_mult_timing();
    test_back_to_back();
    test_mthi_madd();
    test_msub_busy_start();
    test_flush();
`ifdef HILO_DIV_EN
    test_div();
`else
    test_illegal_div();
`endif
    repeat (2) @(negedge Clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL pending_ops: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
